// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage feeding the pattern recognizer's serial input.
// Valid/ready word intake, MSB/LSB-first shifting, end-of-word pulse, optional idle gap.
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   GAP      = 1,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic             order;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
    assign accept   = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            sreg    <= '0;
            order   <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sreg    <= din;
                order   <= msb_first;
                bit_cnt <= '0;
            end else if (state == S_SHIFT) begin
                sreg    <= order ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                bit_cnt <= bit_cnt + CW'(1);
            end
            // gap counter restarts every time a word is shifting, so GAP always begins at 0
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        a          = IDLE_BIT;
        a_valid    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a       = order ? sreg[WIDTH-1] : sreg[0];
                a_valid = 1'b1;
                busy    = 1'b1;
                done    = last_bit;
                // with no gap the next word may be taken on the last bit, keeping the line full
                din_ready = (GAP == 0) && last_bit;
                if (last_bit) begin
                    if (din_valid && (GAP == 0)) begin
                        state_next = S_SHIFT;
                    end else if (GAP > 0) begin
                        state_next = S_GAP;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one instance with a 1-cycle gap, one with no gap.
module tb_bit_serializer;

    logic       clk;
    logic       reset;

    logic [7:0] din1;
    logic       dv1, dr1, msb1, a1, av1, busy1, done1;
    logic [7:0] din0;
    logic       dv0, dr0, msb0, a0, av0, busy0, done0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [4:0] obs;
    logic [4:0] exp;

    // small stand-in for the downstream recognizer: pulse one cycle after a "01" on the line
    logic prev_a;
    logic y_det;

    bit_serializer #(.WIDTH(8), .GAP(1), .IDLE_BIT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .din(din1), .din_valid(dv1), .din_ready(dr1),
        .msb_first(msb1), .a(a1), .a_valid(av1), .busy(busy1), .done(done1)
    );

    bit_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .din(din0), .din_valid(dv0), .din_ready(dr0),
        .msb_first(msb0), .a(a0), .a_valid(av0), .busy(busy0), .done(done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (reset) begin
            prev_a <= 1'b1;
            y_det  <= 1'b0;
        end else begin
            y_det <= av1 && !prev_a && a1;
            if (av1) prev_a <= a1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // obs/exp layout: {a, a_valid, busy, done, din_ready}
    task automatic test_reset();
        reset = 1'b1;
        dv1 = 1'b1; din1 = 8'hFF; msb1 = 1'b1;
        dv0 = 1'b1; din0 = 8'hFF; msb0 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            obs = {a1, av1, busy1, done1, dr1};
            exp = 5'b10001;
            total_cnt++;
            if (obs !== exp) $display("FAIL reset1 cyc%0d got %b want %b", c, obs, exp);
            else pass_cnt++;
            obs = {a0, av0, busy0, done0, dr0};
            total_cnt++;
            if (obs !== exp) $display("FAIL reset0 cyc%0d got %b want %b", c, obs, exp);
            else pass_cnt++;
        end
        reset = 1'b0;
        dv1 = 1'b0;
        dv0 = 1'b0;
        tick();
        obs = {a1, av1, busy1, done1, dr1};
        exp = 5'b10001;
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_release got %b want %b", obs, exp);
        else pass_cnt++;
    endtask

    task automatic send1(input string name, input logic [7:0] word, input logic order,
                         input logic [7:0] bits, input logic scramble);
        din1 = word; msb1 = order; dv1 = 1'b1;
        total_cnt++;
        if (dr1 !== 1'b1) $display("FAIL %s ready_before got %b want 1", name, dr1);
        else pass_cnt++;
        tick();
        dv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (scramble) begin
                msb1 = ~msb1;
                din1 = din1 ^ 8'h5A;
            end
            obs = {a1, av1, busy1, done1, dr1};
            exp = {bits[7-i], 1'b1, 1'b1, (i == 7), 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL %s bit%0d got %b want %b", name, i, obs, exp);
            else pass_cnt++;
            tick();
        end
        obs = {a1, av1, busy1, done1, dr1};
        exp = 5'b10100;
        total_cnt++;
        if (obs !== exp) $display("FAIL %s gap got %b want %b", name, obs, exp);
        else pass_cnt++;
        tick();
        obs = {a1, av1, busy1, done1, dr1};
        exp = 5'b10001;
        total_cnt++;
        if (obs !== exp) $display("FAIL %s idle_after got %b want %b", name, obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_msb_a5();
        send1("msb_a5", 8'hA5, 1'b1, 8'b1010_0101, 1'b0);
    endtask

    task automatic test_lsb_0f();
        send1("lsb_0f", 8'h0F, 1'b0, 8'b1111_0000, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'b1111_0000_0000_1111;
        din0 = 8'hF0; msb0 = 1'b1; dv0 = 1'b1;
        tick();
        din0 = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) dv0 = 1'b0;
            obs = {a0, av0, busy0, done0, dr0};
            exp = {stream[15-i], 1'b1, 1'b1, (i == 7 || i == 15), (i == 7 || i == 15)};
            total_cnt++;
            if (obs !== exp) $display("FAIL b2b cyc%0d got %b want %b", i + 1, obs, exp);
            else pass_cnt++;
            tick();
        end
        obs = {a0, av0, busy0, done0, dr0};
        exp = 5'b10001;
        total_cnt++;
        if (obs !== exp) $display("FAIL b2b idle_after got %b want %b", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        din1 = 8'hFF; msb1 = 1'b1; dv1 = 1'b1;
        tick();
        dv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs = {a1, av1, busy1, done1, dr1};
            exp = 5'b11100;
            total_cnt++;
            if (obs !== exp) $display("FAIL rst_mid bit%0d got %b want %b", i, obs, exp);
            else pass_cnt++;
            if (i == 2) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        obs = {a1, av1, busy1, done1, dr1};
        exp = 5'b10001;
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_mid after got %b want %b", obs, exp);
        else pass_cnt++;
        send1("after_rst_81", 8'h81, 1'b1, 8'b1000_0001, 1'b0);
    endtask

    task automatic test_chain();
        logic [7:0] bits;
        bits = 8'b1101_1011;
        din1 = 8'hDB; msb1 = 1'b1; dv1 = 1'b1;
        tick();
        dv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if ({a1, av1} !== {bits[7-i], 1'b1}) $display("FAIL chain bit%0d got %b want %b", i, {a1, av1}, {bits[7-i], 1'b1});
            else pass_cnt++;
            total_cnt++;
            if (y_det !== (i == 4 || i == 7)) $display("FAIL chain y cyc%0d got %b want %b", i, y_det, (i == 4 || i == 7));
            else pass_cnt++;
            tick();
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        din1 = '0; dv1 = 1'b0; msb1 = 1'b1;
        din0 = '0; dv0 = 1'b0; msb0 = 1'b1;
        test_reset();
        test_msb_a5();
        test_lsb_0f();
        test_back_to_back();
        test_reset_mid_word();
        test_chain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
